// File: rtl/memory_stage_pipepl.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_pipepl
// Description : Y86-64 M stage with the E/M pipeline register and a
//               byte-addressed little-endian data memory (8-byte words).
//               Optional MEM_ALIGN_CHECK_EN: misaligned accesses raise ADR.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage_pipepl #(
  parameter int         MEM_BYTES = 1024,
  parameter logic [2:0] STAT_AOK  = 3'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  EE_stat,
  input  logic [3:0]  EE_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] EE_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  EE_dstM,
  input  logic        M_bubble,
  output logic [2:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [2:0]  m_stat,
  output logic        dmem_error
);

  localparam int          c_AW       = $clog2(MEM_BYTES);
  localparam logic [2:0]  c_STAT_ADR = 3'd3;
  localparam logic [3:0]  c_I_NOP    = 4'h1;
  localparam logic [3:0]  c_I_RMMOVQ = 4'h4;
  localparam logic [3:0]  c_I_MRMOVQ = 4'h5;
  localparam logic [3:0]  c_I_CALL   = 4'h8;
  localparam logic [3:0]  c_I_RET    = 4'h9;
  localparam logic [3:0]  c_I_PUSHQ  = 4'hA;
  localparam logic [3:0]  c_I_POPQ   = 4'hB;
  localparam logic [3:0]  c_REG_NONE = 4'hF;
  localparam logic [63:0] c_ADDR_MAX = 64'(MEM_BYTES - 8);

  logic [2:0]  stat_q,  stat_d;
  logic [3:0]  icode_q, icode_d;
  logic        cnd_q,   cnd_d;
  logic [63:0] vale_q,  vale_d;
  logic [63:0] vala_q,  vala_d;
  logic [3:0]  dste_q,  dste_d;
  logic [3:0]  dstm_q,  dstm_d;

  logic [7:0]  mem_q [MEM_BYTES];

  logic [63:0]     w_addr;
  logic [c_AW-1:0] w_idx;
  logic            w_mem_read;
  logic            w_mem_write;
  logic            w_align_err;
  logic            w_dmem_error;
  logic            w_wr_en;
  logic [63:0]     w_rd_data;

  // Reset and bubble both load the NOP image; reset wins only by being first.
  always_comb begin
    stat_d  = EE_stat;
    icode_d = EE_icode;
    cnd_d   = (e_cnd === 1'b1);
    vale_d  = e_valE;
    vala_d  = EE_valA;
    dste_d  = e_dstE;
    dstm_d  = EE_dstM;
    if (reset || M_bubble) begin
      stat_d  = STAT_AOK;
      icode_d = c_I_NOP;
      cnd_d   = 1'b0;
      vale_d  = '0;
      vala_d  = '0;
      dste_d  = c_REG_NONE;
      dstm_d  = c_REG_NONE;
    end
  end

  always_ff @(posedge clk) begin
    stat_q  <= stat_d;
    icode_q <= icode_d;
    cnd_q   <= cnd_d;
    vale_q  <= vale_d;
    vala_q  <= vala_d;
    dste_q  <= dste_d;
    dstm_q  <= dstm_d;
  end

  always_comb begin
    w_addr      = '0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    case (icode_q)
      c_I_RMMOVQ, c_I_CALL, c_I_PUSHQ: begin
        w_addr      = vale_q;
        w_mem_write = 1'b1;
      end
      c_I_MRMOVQ: begin
        w_addr     = vale_q;
        w_mem_read = 1'b1;
      end
      c_I_RET, c_I_POPQ: begin
        w_addr     = vala_q;
        w_mem_read = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign w_align_err = (w_addr[2:0] != 3'b000);
`else
  assign w_align_err = 1'b0;
`endif

  // Unsigned 64-bit compare so huge addresses cannot wrap into range.
  assign w_dmem_error = (w_mem_read || w_mem_write) &&
                        ((w_addr > c_ADDR_MAX) || w_align_err);
  assign w_idx        = w_addr[c_AW-1:0];
  assign w_wr_en      = w_mem_write && !w_dmem_error && !reset &&
                        (stat_q == STAT_AOK);

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < 8; k++) begin
      w_rd_data[8*k +: 8] = mem_q[w_idx + c_AW'(k)];
    end
  end

  // Memory is never cleared by reset; only a legal AOK store updates it.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[w_idx + c_AW'(k)] <= vala_q[8*k +: 8];
      end
    end
  end

  assign m_valM     = (w_mem_read && !w_dmem_error) ? w_rd_data : 64'd0;
  assign m_stat     = w_dmem_error ? c_STAT_ADR : stat_q;
  assign dmem_error = w_dmem_error;

  assign M_stat  = stat_q;
  assign M_icode = icode_q;
  assign M_cnd   = cnd_q;
  assign M_valE  = vale_q;
  assign M_valA  = vala_q;
  assign M_dstE  = dste_q;
  assign M_dstM  = dstm_q;

endmodule
`default_nettype wire
